// File: rtl/vga_game_ctrl.sv
// vga_game_ctrl: frame-synchronous game sequencer sitting between the PS/2
// key decoder and the VGA renderer. Owns ball/player positions and the game
// state. Each qualifying vertical-blank tick runs a MOVE cycle followed by a
// CHECK cycle (bounce + collision).
// Optional feature macro: VGA_GAME_SCORE_EN builds the survival score counter;
// without it the score output is tied to zero.
module vga_game_ctrl #(
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int BALL_R    = 30,
    parameter int USER_R    = 30,
    parameter int BALL_STEP = 1,
    parameter int USER_STEP = 2,
    parameter int BALL_X0   = 200,
    parameter int BALL_Y0   = 200,
    parameter int USER_X0   = 100,
    parameter int USER_Y0   = 100,
    parameter int FRAME_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [7:0]  key_code,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [10:0] user_x,
    output logic [10:0] user_y,
    output logic [1:0]  game_state,
    output logic        upd_busy,
    output logic        hit,
    output logic [15:0] score
);

    localparam logic [7:0] KEY_START = 8'h29;
    localparam logic [7:0] KEY_PAUSE = 8'h4D;
    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;

    localparam logic [10:0] B_STEP = 11'(BALL_STEP);
    localparam logic [10:0] U_STEP = 11'(USER_STEP);
    localparam logic [10:0] B_MIN  = 11'(BALL_R);
    localparam logic [10:0] BX_MAX = 11'(H_ACT - BALL_R);
    localparam logic [10:0] BY_MAX = 11'(V_ACT - BALL_R);
    localparam logic [10:0] U_MIN  = 11'(USER_R);
    localparam logic [10:0] UX_MAX = 11'(H_ACT - USER_R);
    localparam logic [10:0] UY_MAX = 11'(V_ACT - USER_R);
    localparam logic [22:0] HIT_DIST_SQ = 23'((BALL_R + USER_R) * (BALL_R + USER_R));

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_MOVE, ST_CHECK, ST_PAUSE, ST_OVER
    } state_t;

    state_t state_q, state_d;
    logic [10:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [10:0] user_x_q, user_x_d, user_y_q, user_y_d;
    logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] key_prev_q, key_prev_d;
    logic hit_q, hit_d;
    logic reload, busy, start_cmd, pause_cmd, collide;
    logic [10:0] dx_abs, dy_abs;
    logic [21:0] dx_sq, dy_sq;
    logic [22:0] dist_sq;

    // Step one axis towards inc/dec, saturating at the [lo, hi] range limits.
    function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic inc,
                                              input logic [10:0] step, input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [11:0] sum;
        logic [11:0] floor_v;
        sum     = {1'b0, pos} + {1'b0, step};
        floor_v = {1'b0, lo} + {1'b0, step};
        if (inc)
            step_axis = (sum >= {1'b0, hi}) ? hi : sum[10:0];
        else
            step_axis = ({1'b0, pos} <= floor_v) ? lo : pos - step;
    endfunction

    assign busy      = (state_q == ST_MOVE) || (state_q == ST_CHECK);
    assign start_cmd = (key_code != key_prev_q) && (key_code == KEY_START);
    assign pause_cmd = (key_code != key_prev_q) && (key_code == KEY_PAUSE);

    // Squared centre distance between ball and player, full width so nothing truncates.
    always_comb begin
        dx_abs  = (ball_x_q >= user_x_q) ? ball_x_q - user_x_q : user_x_q - ball_x_q;
        dy_abs  = (ball_y_q >= user_y_q) ? ball_y_q - user_y_q : user_y_q - ball_y_q;
        dx_sq   = 22'(dx_abs) * 22'(dx_abs);
        dy_sq   = 22'(dy_abs) * 22'(dy_abs);
        dist_sq = 23'(dx_sq) + 23'(dy_sq);
        collide = (dist_sq <= HIT_DIST_SQ);
    end

    // Sequencer: command handling, frame division, MOVE/CHECK phases and reload.
    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        user_x_d   = user_x_q;
        user_y_d   = user_y_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        cnt_d      = cnt_q;
        hit_d      = 1'b0;
        reload     = 1'b0;
        key_prev_d = busy ? key_prev_q : key_code;
        case (state_q)
            ST_IDLE: if (start_cmd) reload = 1'b1;
            ST_WAIT: begin
                if (pause_cmd) begin
                    state_d = ST_PAUSE;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_MOVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_MOVE: begin
                ball_x_d = step_axis(ball_x_q, dir_x_q, B_STEP, B_MIN, BX_MAX);
                ball_y_d = step_axis(ball_y_q, dir_y_q, B_STEP, B_MIN, BY_MAX);
                case (key_code)
                    KEY_UP:    user_y_d = step_axis(user_y_q, 1'b0, U_STEP, U_MIN, UY_MAX);
                    KEY_DOWN:  user_y_d = step_axis(user_y_q, 1'b1, U_STEP, U_MIN, UY_MAX);
                    KEY_LEFT:  user_x_d = step_axis(user_x_q, 1'b0, U_STEP, U_MIN, UX_MAX);
                    KEY_RIGHT: user_x_d = step_axis(user_x_q, 1'b1, U_STEP, U_MIN, UX_MAX);
                    default:   user_x_d = user_x_q;
                endcase
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (ball_x_q <= B_MIN)       dir_x_d = 1'b1;
                else if (ball_x_q >= BX_MAX) dir_x_d = 1'b0;
                if (ball_y_q <= B_MIN)       dir_y_d = 1'b1;
                else if (ball_y_q >= BY_MAX) dir_y_d = 1'b0;
                if (collide) begin
                    hit_d   = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PAUSE: begin
                if (pause_cmd)      state_d = ST_WAIT;
                else if (start_cmd) reload  = 1'b1;
            end
            ST_OVER: if (start_cmd) reload = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        if (reload) begin
            ball_x_d = 11'(BALL_X0);
            ball_y_d = 11'(BALL_Y0);
            user_x_d = 11'(USER_X0);
            user_y_d = 11'(USER_Y0);
            dir_x_d  = 1'b1;
            dir_y_d  = 1'b0;
            cnt_d    = '0;
            state_d  = ST_WAIT;
        end
    end

    // State and position registers, restored to start values on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ball_x_q   <= 11'(BALL_X0);
            ball_y_q   <= 11'(BALL_Y0);
            user_x_q   <= 11'(USER_X0);
            user_y_q   <= 11'(USER_Y0);
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b0;
            cnt_q      <= '0;
            key_prev_q <= 8'h00;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            user_x_q   <= user_x_d;
            user_y_q   <= user_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_prev_d;
            hit_q      <= hit_d;
        end
    end

    // Map internal sequencer states onto the renderer-visible game state code.
    always_comb begin
        game_state = 2'b00;
        case (state_q)
            ST_WAIT, ST_MOVE, ST_CHECK: game_state = 2'b01;
            ST_PAUSE:                   game_state = 2'b10;
            ST_OVER:                    game_state = 2'b11;
            default:                    game_state = 2'b00;
        endcase
    end

    assign ball_x   = ball_x_q;
    assign ball_y   = ball_y_q;
    assign user_x   = user_x_q;
    assign user_y   = user_y_q;
    assign upd_busy = busy;
    assign hit      = hit_q;

`ifdef VGA_GAME_SCORE_EN
    logic [15:0] score_q, score_d;

    // Survival score: one point per clean CHECK, saturating, cleared on reload.
    always_comb begin
        score_d = score_q;
        if (reload)
            score_d = 16'h0000;
        else if ((state_q == ST_CHECK) && !collide && (score_q != 16'hFFFF))
            score_d = score_q + 16'd1;
    end

    // Score register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) score_q <= 16'h0000;
        else      score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_game_ctrl.sv
// Testbench for vga_game_ctrl: two instances (FRAME_DIV=1 and FRAME_DIV=3)
// share stimulus and are compared against a behavioural game model.
module tb_vga_game_ctrl;

    localparam int H = 640, V = 480, BR = 30, UR = 30, BSTEP = 1, USTEP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic [10:0] bx_o [2];
    logic [10:0] by_o [2];
    logic [10:0] ux_o [2];
    logic [10:0] uy_o [2];
    logic [1:0]  gs_o [2];
    logic        busy_o [2];
    logic        hit_o [2];
    logic [15:0] sc_o [2];

    int vectors = 0;
    int miscompares = 0;

    // Game model state: 0 idle, 1 run, 2 pause, 3 over; busy_left counts remaining update cycles.
    int m_bx[2], m_by[2], m_ux[2], m_uy[2], m_dx[2], m_dy[2];
    int m_state[2], m_cnt[2], m_busy[2], m_score[2];
    bit m_hit[2];
    logic [7:0] m_prev[2];

    always #5 clk = ~clk;

    vga_game_ctrl u_div1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_code(key_code),
        .ball_x(bx_o[0]), .ball_y(by_o[0]), .user_x(ux_o[0]), .user_y(uy_o[0]),
        .game_state(gs_o[0]), .upd_busy(busy_o[0]), .hit(hit_o[0]), .score(sc_o[0])
    );

    vga_game_ctrl #(.FRAME_DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_code(key_code),
        .ball_x(bx_o[1]), .ball_y(by_o[1]), .user_x(ux_o[1]), .user_y(uy_o[1]),
        .game_state(gs_o[1]), .upd_busy(busy_o[1]), .hit(hit_o[1]), .score(sc_o[1])
    );

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int exp_score(input int d);
`ifdef VGA_GAME_SCORE_EN
        return m_score[d];
`else
        return (d < 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_reload(input int d);
        m_bx[d] = 200; m_by[d] = 200; m_ux[d] = 100; m_uy[d] = 100;
        m_dx[d] = 1; m_dy[d] = -1; m_cnt[d] = 0; m_score[d] = 0; m_state[d] = 1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            model_reload(d);
            m_state[d] = 0; m_busy[d] = 0; m_hit[d] = 0; m_prev[d] = 8'h00;
        end
    endtask

    // One clock edge of the game rules for instance d, using the current inputs.
    task automatic model_edge(input int d);
        bit start_c, pause_c;
        m_hit[d] = 0;
        if (m_busy[d] == 2) begin
            m_bx[d] = clampi(m_bx[d] + m_dx[d] * BSTEP, BR, H - BR);
            m_by[d] = clampi(m_by[d] + m_dy[d] * BSTEP, BR, V - BR);
            case (key_code)
                8'h1D: m_uy[d] = clampi(m_uy[d] - USTEP, UR, V - UR);
                8'h1B: m_uy[d] = clampi(m_uy[d] + USTEP, UR, V - UR);
                8'h1C: m_ux[d] = clampi(m_ux[d] - USTEP, UR, H - UR);
                8'h23: m_ux[d] = clampi(m_ux[d] + USTEP, UR, H - UR);
                default: ;
            endcase
            m_busy[d] = 1;
        end else if (m_busy[d] == 1) begin
            if (m_bx[d] <= BR) m_dx[d] = 1; else if (m_bx[d] >= H - BR) m_dx[d] = -1;
            if (m_by[d] <= BR) m_dy[d] = 1; else if (m_by[d] >= V - BR) m_dy[d] = -1;
            if ((m_bx[d] - m_ux[d]) ** 2 + (m_by[d] - m_uy[d]) ** 2 <= (BR + UR) ** 2) begin
                m_hit[d] = 1; m_state[d] = 3;
            end else if (m_score[d] < 65535) begin
                m_score[d]++;
            end
            m_busy[d] = 0;
        end else begin
            start_c = (key_code != m_prev[d]) && (key_code == 8'h29);
            pause_c = (key_code != m_prev[d]) && (key_code == 8'h4D);
            m_prev[d] = key_code;
            case (m_state[d])
                0: if (start_c) model_reload(d);
                1: begin
                    if (pause_c) m_state[d] = 2;
                    else if (frame_tick) begin
                        m_cnt[d]++;
                        if (m_cnt[d] == div_of(d)) begin m_cnt[d] = 0; m_busy[d] = 2; end
                    end
                end
                2: if (pause_c) m_state[d] = 1; else if (start_c) model_reload(d);
                default: if (start_c) model_reload(d);
            endcase
        end
    endtask

    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle(); cycle(); cycle();
    endtask

    task automatic press(input logic [7:0] k);
        key_code = 8'h00; cycle(); key_code = k; cycle();
    endtask

    task automatic test_reset();
        frame_tick = 1'b0; key_code = 8'h00; rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        #6;
        for (int d = 0; d < 2; d++) begin
            vectors++; if (bx_o[d] !== 11'd200) begin miscompares++; $display("[TB] FAIL reset_ball_x dut%0d got=%0d exp=200", d, bx_o[d]); end
            vectors++; if (by_o[d] !== 11'd200) begin miscompares++; $display("[TB] FAIL reset_ball_y dut%0d got=%0d exp=200", d, by_o[d]); end
            vectors++; if (ux_o[d] !== 11'd100) begin miscompares++; $display("[TB] FAIL reset_user_x dut%0d got=%0d exp=100", d, ux_o[d]); end
            vectors++; if (uy_o[d] !== 11'd100) begin miscompares++; $display("[TB] FAIL reset_user_y dut%0d got=%0d exp=100", d, uy_o[d]); end
            vectors++; if (gs_o[d] !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_state dut%0d got=%0d exp=0", d, gs_o[d]); end
            vectors++; if (busy_o[d] !== 1'b0 || hit_o[d] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_hit dut%0d got=%b%b exp=00", d, busy_o[d], hit_o[d]); end
            vectors++; if (sc_o[d] !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_score dut%0d got=%0d exp=0", d, sc_o[d]); end
        end
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_start();
        press(8'h29);
        for (int d = 0; d < 2; d++) begin
            vectors++; if (gs_o[d] !== 2'b01) begin miscompares++; $display("[TB] FAIL start_state dut%0d got=%0d exp=1", d, gs_o[d]); end
            vectors++; if (bx_o[d] !== 11'd200 || by_o[d] !== 11'd200) begin miscompares++; $display("[TB] FAIL start_ball dut%0d got=(%0d,%0d) exp=(200,200)", d, bx_o[d], by_o[d]); end
            vectors++; if (ux_o[d] !== 11'd100 || uy_o[d] !== 11'd100) begin miscompares++; $display("[TB] FAIL start_user dut%0d got=(%0d,%0d) exp=(100,100)", d, ux_o[d], uy_o[d]); end
        end
    endtask

    task automatic test_update_latency();
        frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
        vectors++; if (busy_o[0] !== 1'b1 || bx_o[0] !== 11'd200) begin miscompares++; $display("[TB] FAIL lat_clk1 got busy=%b x=%0d exp busy=1 x=200", busy_o[0], bx_o[0]); end
        cycle();
        vectors++; if (busy_o[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_clk2_busy got=%b exp=1", busy_o[0]); end
        vectors++; if (bx_o[0] !== 11'd201 || by_o[0] !== 11'd199) begin miscompares++; $display("[TB] FAIL lat_clk2_ball got=(%0d,%0d) exp=(201,199)", bx_o[0], by_o[0]); end
        cycle();
        vectors++; if (busy_o[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_clk3_busy got=%b exp=0", busy_o[0]); end
        vectors++; if (sc_o[0] !== 16'(exp_score(0))) begin miscompares++; $display("[TB] FAIL lat_score got=%0d exp=%0d", sc_o[0], exp_score(0)); end
        cycle();
    endtask

    task automatic test_user_move();
        key_code = 8'h23;
        repeat (3) tick();
        vectors++; if (ux_o[0] !== 11'd106 || uy_o[0] !== 11'd100) begin miscompares++; $display("[TB] FAIL move_right got=(%0d,%0d) exp=(106,100)", ux_o[0], uy_o[0]); end
        vectors++; if (ux_o[1] !== 11'(m_ux[1])) begin miscompares++; $display("[TB] FAIL move_right_div3 got=%0d exp=%0d", ux_o[1], m_ux[1]); end
    endtask

    task automatic test_user_clamp();
        key_code = 8'h1C;
        repeat (40) tick();
        vectors++; if (ux_o[0] !== 11'd30) begin miscompares++; $display("[TB] FAIL clamp_left got=%0d exp=30", ux_o[0]); end
        tick();
        vectors++; if (ux_o[0] !== 11'd30 || uy_o[0] !== 11'd100) begin miscompares++; $display("[TB] FAIL clamp_hold got=(%0d,%0d) exp=(30,100)", ux_o[0], uy_o[0]); end
        vectors++; if (ux_o[1] !== 11'(m_ux[1]) || bx_o[1] !== 11'(m_bx[1])) begin miscompares++; $display("[TB] FAIL clamp_div3 got=(%0d,%0d) exp=(%0d,%0d)", ux_o[1], bx_o[1], m_ux[1], m_bx[1]); end
    endtask

    task automatic test_pause();
        int sx[2], sy[2];
        for (int d = 0; d < 2; d++) begin sx[d] = m_bx[d]; sy[d] = m_by[d]; end
        key_code = 8'h4D; frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            vectors++; if (gs_o[d] !== 2'b10) begin miscompares++; $display("[TB] FAIL pause_state dut%0d got=%0d exp=2", d, gs_o[d]); end
            vectors++; if (bx_o[d] !== 11'(sx[d]) || by_o[d] !== 11'(sy[d])) begin miscompares++; $display("[TB] FAIL pause_frozen dut%0d got=(%0d,%0d) exp=(%0d,%0d)", d, bx_o[d], by_o[d], sx[d], sy[d]); end
        end
        press(8'h4D);
        for (int d = 0; d < 2; d++) begin
            vectors++; if (gs_o[d] !== 2'b01) begin miscompares++; $display("[TB] FAIL resume_state dut%0d got=%0d exp=1", d, gs_o[d]); end
        end
    endtask

    task automatic test_busy_tick();
        int sx, sy;
        key_code = 8'h00; sx = m_bx[0]; sy = m_by[0];
        frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
        cycle(); cycle(); cycle();
        vectors++; if (bx_o[0] !== 11'(sx + 1) || by_o[0] !== 11'(sy - 1)) begin miscompares++; $display("[TB] FAIL busy_tick_ignored got=(%0d,%0d) exp=(%0d,%0d)", bx_o[0], by_o[0], sx + 1, sy - 1); end
        vectors++; if (bx_o[1] !== 11'(m_bx[1]) || busy_o[1] !== (m_busy[1] > 0)) begin miscompares++; $display("[TB] FAIL busy_tick_div3 got=(%0d,%b) exp=(%0d,%b)", bx_o[1], busy_o[1], m_bx[1], m_busy[1] > 0); end
    endtask

    task automatic test_frame_div();
        int r0, r1;
        r0 = 0; r1 = 0;
        repeat (9) begin
            frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
            if (busy_o[0] === 1'b1) r0++;
            if (busy_o[1] === 1'b1) r1++;
            cycle(); cycle(); cycle();
        end
        vectors++; if (r0 != 9) begin miscompares++; $display("[TB] FAIL div1_updates got=%0d exp=9", r0); end
        vectors++; if (r1 != 3) begin miscompares++; $display("[TB] FAIL div3_updates got=%0d exp=3", r1); end
    endtask

    task automatic test_collision();
        int hit_k;
        hit_k = 0;
        press(8'h4D);
        press(8'h29);
        vectors++; if (gs_o[0] !== 2'b01 || bx_o[0] !== 11'd200 || ux_o[0] !== 11'd100) begin miscompares++; $display("[TB] FAIL restart_from_pause got=(%0d,%0d,%0d) exp=(1,200,100)", gs_o[0], bx_o[0], ux_o[0]); end
        key_code = 8'h23;
        for (int k = 1; k <= 150 && hit_k == 0; k++) begin
            frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle(); cycle();
            vectors++; if (hit_o[0] !== m_hit[0] || gs_o[0] !== 2'(m_state[0])) begin miscompares++; $display("[TB] FAIL coll_step%0d got hit=%b st=%0d exp hit=%b st=%0d", k, hit_o[0], gs_o[0], m_hit[0], m_state[0]); end
            if (m_hit[0]) hit_k = k;
            cycle();
        end
        vectors++; if (hit_k != 58) begin miscompares++; $display("[TB] FAIL coll_update_index got=%0d exp=58", hit_k); end
        vectors++; if (hit_o[0] !== 1'b0 || gs_o[0] !== 2'b11) begin miscompares++; $display("[TB] FAIL coll_pulse_end got hit=%b st=%0d exp hit=0 st=3", hit_o[0], gs_o[0]); end
        repeat (3) tick();
        vectors++; if (bx_o[0] !== 11'd258 || by_o[0] !== 11'd142 || ux_o[0] !== 11'd216 || uy_o[0] !== 11'd100) begin miscompares++; $display("[TB] FAIL over_frozen got=(%0d,%0d,%0d,%0d) exp=(258,142,216,100)", bx_o[0], by_o[0], ux_o[0], uy_o[0]); end
        press(8'h29);
        vectors++; if (gs_o[0] !== 2'b01 || bx_o[0] !== 11'd200 || by_o[0] !== 11'd200 || ux_o[0] !== 11'd100) begin miscompares++; $display("[TB] FAIL over_restart got=(%0d,%0d,%0d,%0d) exp=(1,200,200,100)", gs_o[0], bx_o[0], by_o[0], ux_o[0]); end
        vectors++; if (sc_o[0] !== 16'(exp_score(0))) begin miscompares++; $display("[TB] FAIL restart_score got=%0d exp=%0d", sc_o[0], exp_score(0)); end
    endtask

    task automatic test_wall_bounce();
        int k30, k610, k609;
        k30 = 0; k610 = 0; k609 = 0;
        key_code = 8'h1D;
        for (int k = 1; k <= 500 && k609 == 0; k++) begin
            tick();
            vectors++; if (bx_o[0] !== 11'(m_bx[0]) || by_o[0] !== 11'(m_by[0]) || ux_o[0] !== 11'(m_ux[0]) || uy_o[0] !== 11'(m_uy[0])) begin miscompares++; $display("[TB] FAIL wall_step%0d got=(%0d,%0d,%0d,%0d) exp=(%0d,%0d,%0d,%0d)", k, bx_o[0], by_o[0], ux_o[0], uy_o[0], m_bx[0], m_by[0], m_ux[0], m_uy[0]); end
            if (k30 == 0 && m_by[0] == 30) k30 = k;
            if (k610 == 0 && m_bx[0] == 610) k610 = k;
            if (k610 != 0 && m_bx[0] == 609) k609 = k;
        end
        vectors++; if (k30 != 170) begin miscompares++; $display("[TB] FAIL wall_top_index got=%0d exp=170", k30); end
        vectors++; if (k610 != 410 || k609 != 411) begin miscompares++; $display("[TB] FAIL wall_right_index got=(%0d,%0d) exp=(410,411)", k610, k609); end
        vectors++; if (uy_o[0] !== 11'd30) begin miscompares++; $display("[TB] FAIL wall_user_top got=%0d exp=30", uy_o[0]); end
    endtask

    task automatic test_random();
        logic [7:0] keys [7];
        keys = '{8'h00, 8'h29, 8'h4D, 8'h1D, 8'h1B, 8'h1C, 8'h23};
        for (int n = 0; n < 2500; n++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) key_code = keys[$urandom_range(0, 6)];
            cycle();
            for (int d = 0; d < 2; d++) begin
                vectors++; if (bx_o[d] !== 11'(m_bx[d]) || by_o[d] !== 11'(m_by[d])) begin miscompares++; $display("[TB] FAIL rand_ball dut%0d n=%0d got=(%0d,%0d) exp=(%0d,%0d)", d, n, bx_o[d], by_o[d], m_bx[d], m_by[d]); end
                vectors++; if (ux_o[d] !== 11'(m_ux[d]) || uy_o[d] !== 11'(m_uy[d])) begin miscompares++; $display("[TB] FAIL rand_user dut%0d n=%0d got=(%0d,%0d) exp=(%0d,%0d)", d, n, ux_o[d], uy_o[d], m_ux[d], m_uy[d]); end
                vectors++; if (gs_o[d] !== 2'(m_state[d]) || busy_o[d] !== (m_busy[d] > 0) || hit_o[d] !== m_hit[d]) begin miscompares++; $display("[TB] FAIL rand_ctrl dut%0d n=%0d got st=%0d busy=%b hit=%b exp st=%0d busy=%b hit=%b", d, n, gs_o[d], busy_o[d], hit_o[d], m_state[d], m_busy[d] > 0, m_hit[d]); end
                vectors++; if (sc_o[d] !== 16'(exp_score(d))) begin miscompares++; $display("[TB] FAIL rand_score dut%0d n=%0d got=%0d exp=%0d", d, n, sc_o[d], exp_score(d)); end
            end
        end
        frame_tick = 1'b0;
    endtask

    // Main sequence of scenarios followed by the summary line.
    initial begin
        test_reset();
        test_start();
        test_update_latency();
        test_user_move();
        test_user_clamp();
        test_pause();
        test_busy_tick();
        test_frame_div();
        test_collision();
        test_wall_bounce();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
